// File: rtl/coherence_arbiter.sv
// Two-dcache coherence arbiter: grants one cache at a time onto the RAM port and runs the snoop handshake.
// Latency: grant registered one cycle after the request is seen; word completion follows ramready combinationally.
// Backpressure: dwait stays high until ramready (or snoop ack for upgrades); snoop waits on cctrans with no timeout.
// Optional build macro COHERENCE_STATS_EN adds stat_snoops / stat_c2c / stat_ramwords counters.
module coherence_arbiter #(
    parameter int ADDR_W = 32,
    parameter int NCORE  = 2
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic [NCORE-1:0]                 dREN,
    input  logic [NCORE-1:0]                 dWEN,
    input  logic [NCORE-1:0][ADDR_W-1:0]     daddr,
    input  logic [NCORE-1:0][ADDR_W-1:0]     dstore,
    input  logic [NCORE-1:0]                 cctrans,
    input  logic [NCORE-1:0]                 ccwrite,
    output logic [NCORE-1:0]                 dwait,
    output logic [NCORE-1:0][ADDR_W-1:0]     dload,
    output logic [NCORE-1:0]                 ccwait,
    output logic [NCORE-1:0]                 ccinv,
    output logic [NCORE-1:0][ADDR_W-1:0]     ccsnoopaddr,
    output logic                             ramREN,
    output logic                             ramWEN,
    output logic [ADDR_W-1:0]                ramaddr,
    output logic [ADDR_W-1:0]                ramstore,
    input  logic [ADDR_W-1:0]                ramload,
    input  logic                             ramready
`ifdef COHERENCE_STATS_EN
    ,
    output logic [31:0]                      stat_snoops,
    output logic [31:0]                      stat_c2c,
    output logic [31:0]                      stat_ramwords
`endif
);

    // The index arithmetic (req/oth as one bit) only works for exactly two caches.
    generate
        if (NCORE != 2) begin : g_bad_ncore
            $error("coherence_arbiter supports NCORE == 2 only");
        end
    endgenerate

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WB    = 3'd1;
    localparam logic [2:0] SNOOP = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] C2C   = 3'd4;

    logic [2:0] state;
    logic       req_q;      // granted cache
    logic       oth;        // the other cache
    logic       rr_last;    // last granted index, loser of the next tie
    logic       snooped_q;  // RD was entered from SNOOP, keep the other cache frozen

    logic [1:0] cls_wb, cls_fill, cls_upg, cls_rd;
    logic [1:0] cand;
    logic [2:0] grant_state;
    logic       pick;

    assign oth      = ~req_q;
    assign cls_wb   = dWEN & ~ccwait;
    assign cls_fill = dREN & cctrans;
    assign cls_upg  = cctrans & ccwrite & ~dREN;
    assign cls_rd   = dREN & ~cctrans;

    // Pick the highest-priority request class present, then break a tie round-robin.
    always_comb begin
        cand        = 2'b00;
        grant_state = IDLE;
        if (|cls_wb) begin
            cand        = cls_wb;
            grant_state = WB;
        end else if (|cls_fill) begin
            cand        = cls_fill;
            grant_state = SNOOP;
        end else if (|cls_upg) begin
            cand        = cls_upg;
            grant_state = SNOOP;
        end else if (|cls_rd) begin
            cand        = cls_rd;
            grant_state = RD;
        end
        pick = (cand == 2'b11) ? ~rr_last : cand[1];
    end

    // Transaction state machine; one transaction in flight at a time.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            rr_last   <= 1'b1;
            snooped_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|cand) begin
                        state     <= grant_state;
                        req_q     <= pick;
                        rr_last   <= pick;
                        snooped_q <= 1'b0;
                    end
                end
                WB: begin
                    if (!dWEN[req_q]) state <= IDLE;
                end
                SNOOP: begin
                    if (cctrans[oth]) begin
                        if (ccwrite[oth]) begin
                            state <= C2C;
                        end else if (dREN[req_q]) begin
                            state     <= RD;
                            snooped_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RD, C2C: begin
                    if (!dREN[req_q]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from the registered state; reset drops strobes and ccwait immediately.
    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            WB: begin
                ramWEN         = 1'b1;
                ramaddr        = daddr[req_q];
                ramstore       = dstore[req_q];
                dwait[req_q]   = ~ramready;
            end
            SNOOP: begin
                ccwait[oth]      = 1'b1;
                ccsnoopaddr[oth] = daddr[req_q];
                ccinv[oth]       = ccwrite[req_q];
                // An upgrade has no data phase, so the ack itself completes it.
                if (cctrans[oth] && !ccwrite[oth] && !dREN[req_q]) dwait[req_q] = 1'b0;
            end
            RD: begin
                ramREN        = 1'b1;
                ramaddr       = daddr[req_q];
                dload[req_q]  = ramload;
                dwait[req_q]  = ~ramready;
                ccwait[oth]   = snooped_q;
            end
            C2C: begin
                // Dirty data goes to the requester and to RAM in the same beat.
                ccwait[oth]   = 1'b1;
                ramWEN        = 1'b1;
                ramaddr       = daddr[oth];
                ramstore      = dstore[oth];
                dload[req_q]  = dstore[oth];
                dwait[req_q]  = ~ramready;
                dwait[oth]    = ~ramready;
            end
            default: ;
        endcase
    end

`ifdef COHERENCE_STATS_EN
    // Event counters: snoop entries, C2C entries and completed RAM words.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_snoops   <= '0;
            stat_c2c      <= '0;
            stat_ramwords <= '0;
        end else begin
            if (state == IDLE && (|cand) && grant_state == SNOOP)
                stat_snoops <= stat_snoops + 32'd1;
            if (state == SNOOP && cctrans[oth] && ccwrite[oth])
                stat_c2c <= stat_c2c + 32'd1;
            if (ramready && (ramREN || ramWEN))
                stat_ramwords <= stat_ramwords + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coherence_arbiter.sv
// Bench for coherence_arbiter: randomized cache transactions against a transaction-level model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Model tracks grant priority/round-robin, expected bus values and event counts.
module tb_coherence_arbiter;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             ramREN, ramWEN, ramready;
    logic [31:0]      ramaddr, ramstore, ramload;
`ifdef COHERENCE_STATS_EN
    logic [31:0]      stat_snoops, stat_c2c, stat_ramwords;
`endif

    int errors = 0;
    int checks = 0;
    bit rr_m;                 // model: last granted core
    int m_snoops, m_c2c, m_words;

    coherence_arbiter #(.ADDR_W(32), .NCORE(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
`ifdef COHERENCE_STATS_EN
        , .stat_snoops(stat_snoops), .stat_c2c(stat_c2c), .stat_ramwords(stat_ramwords)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int k);
        return (k == 0) ? 2'b01 : 2'b10;
    endfunction

    // Request classes: 1 writeback, 2 fill, 3 upgrade, 4 plain read; lower wins.
    function automatic int winner(input int c0, input int c1, input bit last);
        if (c1 == 0) return 0;
        if (c0 == 0) return 1;
        if (c0 < c1) return 0;
        if (c1 < c0) return 1;
        return last ? 0 : 1;
    endfunction

    task automatic drive_req(input int k, input int cls, input bit wr, input logic [31:0] a);
        daddr[k]  = a;
        dstore[k] = $urandom;
        case (cls)
            1: dWEN[k] = 1'b1;
            2: begin dREN[k] = 1'b1; cctrans[k] = 1'b1; ccwrite[k] = wr; end
            3: begin cctrans[k] = 1'b1; ccwrite[k] = 1'b1; end
            4: dREN[k] = 1'b1;
            default: ;
        endcase
    endtask

    task automatic clear_core(input int k);
        dREN[k] = 1'b0; dWEN[k] = 1'b0; cctrans[k] = 1'b0; ccwrite[k] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ccwait"}, 32'(ccwait), 32'h0);
        check({tag, "_dwait"}, 32'(dwait), 32'h3);
        check({tag, "_strobe"}, 32'({ramREN, ramWEN}), 32'h0);
    endtask

    // One data word. md: 0 writeback, 1 RAM read, 2 cache-to-cache.
    task automatic word(input int i, input int md, input bit snooped, input logic [31:0] a, input logic [31:0] d);
        int j = 1 - i;
        int dly = $urandom_range(0, 2);
        logic [1:0] ew;
        daddr[i] = a;
        if (md == 0) dstore[i] = d;
        if (md == 2) begin daddr[j] = a; dstore[j] = d; end
        for (int c = 0; c <= dly; c++) begin
            ramready = (c == dly);
            ramload  = (md == 1) ? d : $urandom;
            @(negedge CLK);
            ew = 2'b11;
            if (ramready) begin
                ew[i] = 1'b0;
                if (md == 2) ew[j] = 1'b0;
            end
            check("w_dwait", 32'(dwait), 32'(ew));
            check("w_ramaddr", ramaddr, a);
            if (md == 1) begin
                check("rd_strobe", 32'({ramREN, ramWEN}), 32'h2);
                check("rd_dload", dload[i], d);
                check("rd_ccwait", 32'(ccwait), snooped ? 32'(onehot(j)) : 32'h0);
            end else begin
                check("wr_strobe", 32'({ramREN, ramWEN}), 32'h1);
                check("wr_ramstore", ramstore, d);
                if (md == 2) begin
                    check("c2c_dload", dload[i], d);
                    check("c2c_ccwait", 32'(ccwait), 32'(onehot(j)));
                end else begin
                    check("wb_ccwait", 32'(ccwait), 32'h0);
                end
            end
            nxt();
        end
        ramready = 1'b0;
        m_words++;
    endtask

    // Full transaction by core i of class cls; core j may raise class ocls in the request cycle only.
    task automatic txn(input int i, input int cls, input int ocls, input bit wr, input bit dirty, input int nw);
        int j = 1 - i;
        logic [31:0] a = {$urandom} & 32'hFFFF_FFF8;
        logic [1:0] ew;
        drive_req(i, cls, wr, a);
        if (ocls != 0) drive_req(j, ocls, $urandom_range(0, 1) == 1, $urandom);
        @(negedge CLK);
        check_idle("req");
        nxt();
        clear_core(j);
        rr_m = (i == 1);
        if (cls == 1) begin
            for (int w = 0; w < nw; w++) word(i, 0, 1'b0, a + 32'(4 * w), $urandom);
            dWEN[i] = 1'b0;
            @(negedge CLK);
            check("wb_exit_dwait", 32'(dwait), 32'h3);
            nxt();
        end else if (cls == 4) begin
            for (int w = 0; w < nw; w++) word(i, 1, 1'b0, a + 32'(4 * w), $urandom);
            clear_core(i);
            nxt();
        end else begin
            m_snoops++;
            for (int c = 0; c < $urandom_range(1, 3); c++) begin
                @(negedge CLK);
                check("sn_ccwait", 32'(ccwait), 32'(onehot(j)));
                check("sn_addr", ccsnoopaddr[j], a);
                check("sn_ccinv", 32'(ccinv), (cls == 3 || wr) ? 32'(onehot(j)) : 32'h0);
                check("sn_strobe", 32'({ramREN, ramWEN}), 32'h0);
                check("sn_dwait", 32'(dwait), 32'h3);
                nxt();
            end
            cctrans[j] = 1'b1;
            ccwrite[j] = (cls == 2) && dirty;
            @(negedge CLK);
            ew = 2'b11;
            if (cls == 3) ew[i] = 1'b0;
            check("ack_dwait", 32'(dwait), 32'(ew));
            check("ack_ccwait", 32'(ccwait), 32'(onehot(j)));
            nxt();
            cctrans[j] = 1'b0;
            if (cls == 3) begin
                clear_core(i);
                clear_core(j);
            end else begin
                if (dirty) m_c2c++;
                for (int w = 0; w < nw; w++) word(i, dirty ? 2 : 1, 1'b1, a + 32'(4 * w), $urandom);
                clear_core(i);
                @(negedge CLK);
                check("exit_ccwait", 32'(ccwait), 32'(onehot(j)));
                nxt();
                clear_core(j);
            end
        end
        @(negedge CLK);
        check_idle("done");
        nxt();
    endtask

    task automatic race(input int c0, input int c1, input bit wr, input bit dirty, input int nw);
        int w = winner(c0, c1, rr_m);
        txn(w, (w == 0) ? c0 : c1, (w == 0) ? c1 : c0, wr, dirty, nw);
    endtask

    initial begin
        nRST = 1'b0;
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        daddr = '0; dstore = '0; ramload = '0; ramready = 1'b0;
        rr_m = 1'b1; m_snoops = 0; m_c2c = 0; m_words = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle("rst");
        check("rst_dload0", dload[0], 32'h0);
        check("rst_dload1", dload[1], 32'h0);
        check("rst_snoopaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_ccinv", 32'(ccinv), 32'h0);
        nRST = 1'b1;
        nxt();

        // Reset in the middle of a read: strobe must drop without a clock.
        dREN[0] = 1'b1; daddr[0] = 32'h100;
        nxt();
        @(negedge CLK);
        check("midrd_ramREN", 32'(ramREN), 32'h1);
        nRST = 1'b0;
        #1;
        check_idle("midrst");
        dREN = '0;
        nxt();
        nRST = 1'b1;
        rr_m = 1'b1;
        nxt();

        // Back-to-back contended fills alternate 0,1,0 starting from core 0.
        race(2, 2, 1'b0, 1'b0, 1);
        race(2, 2, 1'b0, 1'b1, 2);
        race(2, 2, 1'b1, 1'b0, 2);
        txn(0, 2, 0, 1'b0, 1'b0, 1);    // clean fill
        txn(1, 2, 0, 1'b1, 1'b1, 2);    // dirty cache-to-cache, two words
        txn(0, 3, 0, 1'b1, 1'b0, 0);    // upgrade
        race(2, 1, 1'b0, 1'b0, 1);      // writeback from core 1 beats fill from core 0
        race(4, 3, 1'b0, 1'b0, 1);      // upgrade beats plain read

        for (int n = 0; n < 40; n++) begin
            int c0 = $urandom_range(0, 4);
            int c1 = $urandom_range(0, 4);
            if (c0 == 0 && c1 == 0) c0 = 2;
            race(c0, c1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 2));
        end

`ifdef COHERENCE_STATS_EN
        check("stat_snoops", stat_snoops, 32'(m_snoops));
        check("stat_c2c", stat_c2c, 32'(m_c2c));
        check("stat_ramwords", stat_ramwords, 32'(m_words));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
